// File: rtl/instr_issue_unit_if.sv
// Queue-head and execution-lane signal bundle for instr_issue_unit.
// master: queue producer and lane consumer side; slave: the issue unit.
interface instr_issue_unit_if #(
  parameter int unsigned ISSUE_WIDTH  = 3,
  parameter int unsigned LOG_COPY_MAX = 3,
  parameter int unsigned ADDR_W       = 18
);
  logic                          q_valid;
  logic                          q_ready;
  logic [15:0]                   q_instr;
  logic [ADDR_W-1:0]             q_cache_addr;
  logic [ADDR_W-1:0]             q_d_cache_addr;
  logic [ADDR_W-1:0]             q_main_mem_addr;
  logic [ADDR_W-1:0]             q_d_main_mem_addr;
  logic [LOG_COPY_MAX:0]         q_copy_cnt;
  logic [ISSUE_WIDTH-1:0]        lane_valid;
  logic                          lane_ready;
  logic [16*ISSUE_WIDTH-1:0]     lane_instr;
  logic [ADDR_W*ISSUE_WIDTH-1:0] lane_cache_addr;
  logic [ADDR_W*ISSUE_WIDTH-1:0] lane_main_mem_addr;

  modport master (
    output q_valid, q_instr, q_cache_addr, q_d_cache_addr, q_main_mem_addr,
           q_d_main_mem_addr, q_copy_cnt, lane_ready,
    input  q_ready, lane_valid, lane_instr, lane_cache_addr, lane_main_mem_addr
  );

  modport slave (
    input  q_valid, q_instr, q_cache_addr, q_d_cache_addr, q_main_mem_addr,
           q_d_main_mem_addr, q_copy_cnt, lane_ready,
    output q_ready, lane_valid, lane_instr, lane_cache_addr, lane_main_mem_addr
  );
endinterface

// File: rtl/instr_issue_unit.sv
// Expands popped instruction-queue entries into per-copy lane issues, ISSUE_WIDTH per cycle.
// Optional: define ISSUE_PERF_CNT_EN to add perf_issued / perf_stall counters.
module instr_issue_unit #(
  parameter int unsigned ISSUE_WIDTH  = 3,
  parameter int unsigned LOG_COPY_MAX = 3,
  parameter int unsigned ADDR_W       = 18
) (
  input  logic                 clk,
  input  logic                 reset,
  instr_issue_unit_if.slave    io,
  output logic                 busy
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [31:0]          perf_issued,
  output logic [31:0]          perf_stall
`endif
);
  localparam int unsigned CW = LOG_COPY_MAX + 1;

  typedef enum logic [0:0] {StEmpty, StExpand} state_e;

  state_e            state_q, state_d;
  logic [15:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] cache_q, cache_d;
  logic [ADDR_W-1:0] d_cache_q, d_cache_d;
  logic [ADDR_W-1:0] main_q, main_d;
  logic [ADDR_W-1:0] d_main_q, d_main_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     issued_q, issued_d;

  logic [CW-1:0]          rem;
  logic [CW-1:0]          step;
  logic                   last_issue;
  logic                   issue;
  logic                   pop;
  logic                   q_ready;
  logic [ISSUE_WIDTH-1:0] lane_valid;
  logic [ADDR_W-1:0]      idx;

  assign rem        = cnt_q - issued_q;
  assign last_issue = int'(rem) <= int'(ISSUE_WIDTH);
  assign step       = last_issue ? rem : CW'(ISSUE_WIDTH);
  assign issue      = lane_valid[0] && io.lane_ready;
  assign busy       = (state_q == StExpand);
  assign io.q_ready = q_ready;
  assign io.lane_valid = lane_valid;

  // Lane k carries copy issued+k of the held entry; arithmetic wraps at ADDR_W bits.
  always_comb begin
    lane_valid            = '0;
    io.lane_instr         = '0;
    io.lane_cache_addr    = '0;
    io.lane_main_mem_addr = '0;
    idx                   = '0;
    for (int k = 0; k < int'(ISSUE_WIDTH); k++) begin
      idx           = ADDR_W'(issued_q) + ADDR_W'(k);
      lane_valid[k] = (state_q == StExpand) && (int'(rem) > k);
      io.lane_instr[16*k +: 16]                 = instr_q;
      io.lane_cache_addr[ADDR_W*k +: ADDR_W]    = cache_q + idx * d_cache_q;
      io.lane_main_mem_addr[ADDR_W*k +: ADDR_W] = main_q + idx * d_main_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    cache_d   = cache_q;
    d_cache_d = d_cache_q;
    main_d    = main_q;
    d_main_d  = d_main_q;
    cnt_d     = cnt_q;
    issued_d  = issued_q;
    // Pop may coincide with the last issue of the held entry, avoiding a bubble.
    q_ready   = !reset && ((state_q == StEmpty) || (issue && last_issue));
    pop       = io.q_valid && q_ready;
    if (pop) begin
      state_d   = StExpand;
      instr_d   = io.q_instr;
      cache_d   = io.q_cache_addr;
      d_cache_d = io.q_d_cache_addr;
      main_d    = io.q_main_mem_addr;
      d_main_d  = io.q_d_main_mem_addr;
      cnt_d     = (io.q_copy_cnt == '0) ? CW'(1) : io.q_copy_cnt;
      issued_d  = '0;
    end else if (issue) begin
      issued_d = issued_q + step;
      if (last_issue) state_d = StEmpty;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StEmpty;
      instr_q   <= '0;
      cache_q   <= '0;
      d_cache_q <= '0;
      main_q    <= '0;
      d_main_q  <= '0;
      cnt_q     <= '0;
      issued_q  <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      cache_q   <= cache_d;
      d_cache_q <= d_cache_d;
      main_q    <= main_d;
      d_main_q  <= d_main_d;
      cnt_q     <= cnt_d;
      issued_q  <= issued_d;
    end
  end

`ifdef ISSUE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (issue) perf_issued <= perf_issued + 32'(step);
      if (lane_valid[0] && !io.lane_ready) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_issue_unit.sv
// Directed bench for instr_issue_unit with a copy scoreboard fed at stimulus time.
module tb_instr_issue_unit;
  localparam int unsigned IW = 3;
  localparam int unsigned LC = 3;
  localparam int unsigned AW = 18;

  typedef struct packed {
    logic [15:0]   instr;
    logic [AW-1:0] cache;
    logic [AW-1:0] main;
  } copy_t;

  logic clk = 1'b0;
  logic reset;
  logic busy;
`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] perf_issued;
  logic [31:0] perf_stall;
`endif

  int checks   = 0;
  int failures = 0;
  copy_t exp_q[$];

  instr_issue_unit_if #(.ISSUE_WIDTH(IW), .LOG_COPY_MAX(LC), .ADDR_W(AW)) bus ();

  instr_issue_unit #(.ISSUE_WIDTH(IW), .LOG_COPY_MAX(LC), .ADDR_W(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .io          (bus),
    .busy        (busy)
`ifdef ISSUE_PERF_CNT_EN
    ,
    .perf_issued (perf_issued),
    .perf_stall  (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] lane_cache(input int k);
    return bus.lane_cache_addr[AW*k +: AW];
  endfunction

  task automatic drive_entry(input logic [15:0] instr, input logic [AW-1:0] c,
                             input logic [AW-1:0] dc, input logic [AW-1:0] m,
                             input logic [AW-1:0] dm, input int cnt);
    int n;
    n = (cnt == 0) ? 1 : cnt;
    bus.q_valid           = 1'b1;
    bus.q_instr           = instr;
    bus.q_cache_addr      = c;
    bus.q_d_cache_addr    = dc;
    bus.q_main_mem_addr   = m;
    bus.q_d_main_mem_addr = dm;
    bus.q_copy_cnt        = (LC+1)'(cnt);
    for (int i = 0; i < n; i++)
      exp_q.push_back({instr, AW'(c + AW'(i) * dc), AW'(m + AW'(i) * dm)});
  endtask

  // Compare accepted lanes against the scoreboard, then advance one clock.
  task automatic cycle();
    logic accepted;
    copy_t got, want;
    #1;
    if (bus.lane_ready) begin
      for (int k = 0; k < int'(IW); k++) begin
        if (bus.lane_valid[k]) begin
          got = {bus.lane_instr[16*k +: 16], bus.lane_cache_addr[AW*k +: AW],
                 bus.lane_main_mem_addr[AW*k +: AW]};
          checks++;
          assert (exp_q.size() > 0) else begin
            failures++;
            $error("FAIL sb_underflow observed=%0h expected=none", got);
          end
          if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            chk($sformatf("sb_lane%0d", k), 64'(got), 64'(want));
          end
        end
      end
    end
    accepted = bus.q_valid && bus.q_ready;
    @(posedge clk);
    #1;
    if (accepted) bus.q_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 30; i++) begin
      if (!busy && exp_q.size() == 0) break;
      cycle();
    end
    chk({tag, "_drained"}, {63'(exp_q.size()), busy}, 64'd0);
  endtask

  initial begin
    reset                 = 1'b1;
    bus.q_valid           = 1'b0;
    bus.q_instr           = '0;
    bus.q_cache_addr      = '0;
    bus.q_d_cache_addr    = '0;
    bus.q_main_mem_addr   = '0;
    bus.q_d_main_mem_addr = '0;
    bus.q_copy_cnt        = '0;
    bus.lane_ready        = 1'b1;
    @(posedge clk);
    #1;
    cycle();
    chk("rst_qready", 64'(bus.q_ready), 64'd0);
    chk("rst_valid", 64'(bus.lane_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cache", 64'(bus.lane_cache_addr), 64'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_qready", 64'(bus.q_ready), 64'd1);

    // Single copy
    drive_entry(16'h1111, 18'h10, 18'h4, 18'h200, 18'h8, 1);
    cycle();
    chk("t1_valid", 64'(bus.lane_valid), 64'b001);
    chk("t1_cache0", 64'(lane_cache(0)), 64'h10);
    chk("t1_busy", 64'(busy), 64'd1);
    cycle();
    chk("t1_busy_drop", 64'(busy), 64'd0);

    // Eight copies over three issue cycles
    drive_entry(16'h2222, 18'h100, 18'h2, 18'h4000, 18'h10, 8);
    cycle();
    chk("t2_v0", 64'(bus.lane_valid), 64'b111);
    chk("t2_c0", {16'(lane_cache(0)), 16'(lane_cache(1)), 16'(lane_cache(2))},
        64'h0100_0102_0104);
    chk("t2_qr0", 64'(bus.q_ready), 64'd0);
    cycle();
    chk("t2_v1", 64'(bus.lane_valid), 64'b111);
    chk("t2_c1", {16'(lane_cache(0)), 16'(lane_cache(1)), 16'(lane_cache(2))},
        64'h0106_0108_010A);
    cycle();
    chk("t2_v2", 64'(bus.lane_valid), 64'b011);
    chk("t2_c2", {16'(lane_cache(0)), 16'(lane_cache(1))}, 64'h010C_010E);
    chk("t2_qr2", 64'(bus.q_ready), 64'd1);
    drain("t2");

    // Back-to-back entries: pop coincides with last issue
    drive_entry(16'hAAAA, 18'h40, 18'h1, 18'h0, 18'h1, 5);
    cycle();
    drive_entry(16'hBBBB, 18'h80, 18'h10, 18'h300, 18'h4, 2);
    #1;
    chk("t3_v0", 64'(bus.lane_valid), 64'b111);
    chk("t3_qr0", 64'(bus.q_ready), 64'd0);
    cycle();
    chk("t3_v1", 64'(bus.lane_valid), 64'b011);
    chk("t3_qr1", 64'(bus.q_ready), 64'd1);
    cycle();
    chk("t3_b_valid", 64'(bus.lane_valid), 64'b011);
    chk("t3_b_instr", 64'(bus.lane_instr[15:0]), 64'hBBBB);
    chk("t3_b_cache", {32'(lane_cache(0)), 32'(lane_cache(1))}, {32'h80, 32'h90});
    drain("t3");

    // Stall holds lanes
    bus.lane_ready = 1'b0;
    drive_entry(16'h4444, 18'h20, 18'h3, 18'h1000, 18'h2, 4);
    cycle();
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("t4_stall_v%0d", s), 64'(bus.lane_valid), 64'b111);
      chk($sformatf("t4_stall_c%0d", s),
          {16'(lane_cache(0)), 16'(lane_cache(1)), 16'(lane_cache(2))}, 64'h0020_0023_0026);
      chk($sformatf("t4_stall_qr%0d", s), 64'(bus.q_ready), 64'd0);
      cycle();
    end
    bus.lane_ready = 1'b1;
    #1;
    chk("t4_go_v0", 64'(bus.lane_valid), 64'b111);
    cycle();
    chk("t4_go_v1", 64'(bus.lane_valid), 64'b001);
    chk("t4_go_qr", 64'(bus.q_ready), 64'd1);
    drain("t4");

    // Address wrap
    drive_entry(16'h5555, 18'h3FFFE, 18'h1, 18'h3FFFF, 18'h2, 3);
    cycle();
    chk("t5_wrap", {16'(lane_cache(0) >> 2), 16'(lane_cache(1) >> 2), 16'(lane_cache(2))},
        64'hFFFF_FFFF_0000);
    chk("t5_wrap_lo", {62'd0, lane_cache(0)[1:0]}, 64'd2);
    drain("t5");

    // Zero copy count issues one copy
    drive_entry(16'h6666, 18'h7, 18'h5, 18'h9, 18'h1, 0);
    cycle();
    chk("t6_cnt0_valid", 64'(bus.lane_valid), 64'b001);
    drain("t6");

`ifdef ISSUE_PERF_CNT_EN
    chk("perf_issued", 64'(perf_issued), 64'd24);
    chk("perf_stall", 64'(perf_stall), 64'd3);
`endif

    // Reset mid-expansion
    drive_entry(16'h7777, 18'h500, 18'h1, 18'h600, 18'h1, 8);
    cycle();
    chk("t7_v0", 64'(bus.lane_valid), 64'b111);
    cycle();
    reset          = 1'b1;
    bus.lane_ready = 1'b0;
    cycle();
    exp_q.delete();
    chk("t7_rst_valid", 64'(bus.lane_valid), 64'd0);
    chk("t7_rst_busy", 64'(busy), 64'd0);
    chk("t7_rst_qready", 64'(bus.q_ready), 64'd0);
    chk("t7_rst_cache", 64'(bus.lane_cache_addr), 64'd0);
`ifdef ISSUE_PERF_CNT_EN
    chk("t7_perf_zero", {perf_issued, perf_stall}, 64'd0);
`endif
    reset          = 1'b0;
    bus.lane_ready = 1'b1;
    #1;
    chk("t7_qready_after", 64'(bus.q_ready), 64'd1);
    drive_entry(16'h8888, 18'h11, 18'h1, 18'h22, 18'h1, 2);
    cycle();
    chk("t7_recover_valid", 64'(bus.lane_valid), 64'b011);
    drain("t7");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
